// File: rtl/oq_pkt_scheduler_pkg.sv
// Shared definitions for the output-queue packet scheduler: FSM state
// encoding, a log2 helper and the default configuration values.
// Optional feature macro used by the top: OQ_SCHED_HIPRI_EN.
package oq_pkt_scheduler_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } sched_state_t;

    localparam int OQ_SCHED_DATA_WIDTH = 64;
    localparam int OQ_SCHED_CTRL_WIDTH = OQ_SCHED_DATA_WIDTH / 8;
    localparam int OQ_SCHED_NUM_QUEUES = 8;

    // Width of an index into n items; never less than one bit.
    function automatic int oq_log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/oq_rr_arbiter.sv
// Rotating-priority encoder: grants the first requester found searching
// ptr+1, ptr+2, ... (mod NUM_QUEUES). Purely combinational.
module oq_rr_arbiter
    import oq_pkt_scheduler_pkg::*;
#(
    parameter  int NUM_QUEUES = OQ_SCHED_NUM_QUEUES,
    localparam int PTR_W      = oq_log2(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [PTR_W-1:0]      gnt_idx,
    output logic                  gnt_valid
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        // NOTE: every output gets a default before any conditional
        // assignment, otherwise synthesis infers a latch for the paths
        // that leave it untouched.
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int off = NUM_QUEUES; off >= 1; off--) begin
            idx = PTR_W'((int'(ptr) + off) % NUM_QUEUES);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oq_pkt_scheduler.sv
// Packet-granular round-robin scheduler draining NUM_QUEUES output FIFOs
// onto one shared port. Whole packets only, disabled queues skipped,
// one pkt_sent pulse per packet on its EOP word.
// Optional feature: define OQ_SCHED_HIPRI_EN to add hipri_mask, giving the
// lowest-index eligible masked queue strict priority (rr_ptr untouched).
module oq_pkt_scheduler
    import oq_pkt_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = OQ_SCHED_DATA_WIDTH,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = OQ_SCHED_NUM_QUEUES
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_QUEUES-1:0]                       q_empty,
    output logic [NUM_QUEUES-1:0]                       q_rd_en,
    input  logic [NUM_QUEUES*(CTRL_WIDTH+DATA_WIDTH)-1:0] q_dout,
    input  logic [NUM_QUEUES-1:0]                       disable_q,
`ifdef OQ_SCHED_HIPRI_EN
    input  logic [NUM_QUEUES-1:0]                       hipri_mask,
`endif
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic [CTRL_WIDTH-1:0]                       out_ctrl,
    output logic                                        out_wr,
    input  logic                                        out_rdy,
    output logic [NUM_QUEUES-1:0]                       pkt_sent,
    output logic                                        busy
);

    localparam int PTR_W  = oq_log2(NUM_QUEUES);
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;

    sched_state_t          state, state_nxt;
    logic [PTR_W-1:0]      grant, grant_nxt;
    logic [PTR_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [CTRL_WIDTH-1:0] ctrl_prev, ctrl_prev_nxt;
    logic                  out_wr_nxt;

    logic [NUM_QUEUES-1:0] elig;
    logic [PTR_W-1:0]      rr_idx;
    logic                  rr_valid;
    logic [PTR_W-1:0]      sel_idx;
    logic                  sel_valid;
    logic                  sel_hipri;
    logic [WORD_W-1:0]     cur_word;
    logic                  eop;

    assign elig = ~q_empty & ~disable_q;

    oq_rr_arbiter #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_rr_arbiter (
        .req       (elig),
        .ptr       (rr_ptr),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

`ifdef OQ_SCHED_HIPRI_EN
    // Lowest-index eligible high-priority queue overrides the round-robin pick.
    always_comb begin
        sel_idx   = rr_idx;
        sel_valid = rr_valid;
        sel_hipri = 1'b0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (elig[i] && hipri_mask[i]) begin
                sel_idx   = PTR_W'(i);
                sel_valid = 1'b1;
                sel_hipri = 1'b1;
            end
        end
    end
`else
    assign sel_idx   = rr_idx;
    assign sel_valid = rr_valid;
    assign sel_hipri = 1'b0;
`endif

    // Output word is the granted FIFO's registered dout, muxed straight through.
    assign cur_word = q_dout[grant*WORD_W +: WORD_W];
    assign out_ctrl = cur_word[WORD_W-1 -: CTRL_WIDTH];
    assign out_data = cur_word[DATA_WIDTH-1:0];

    // EOP is the first nonzero ctrl after a data word, so a leading module
    // header (nonzero ctrl right after the grant) is never mistaken for it.
    assign eop  = out_wr && (out_ctrl != '0) && (ctrl_prev == '0);
    assign busy = (state == DRAIN);

    // Next-state, read strobe and pkt_sent decode.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        ctrl_prev_nxt = ctrl_prev;
        out_wr_nxt    = 1'b0;
        q_rd_en       = '0;
        pkt_sent      = '0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    grant_nxt     = sel_idx;
                    ctrl_prev_nxt = CTRL_WIDTH'(1);
                    state_nxt     = DRAIN;
                    if (!sel_hipri) begin
                        rr_ptr_nxt = sel_idx;
                    end
                end
            end
            DRAIN: begin
                if (out_wr) begin
                    ctrl_prev_nxt = out_ctrl;
                end
                if (eop) begin
                    pkt_sent[grant] = 1'b1;
                    state_nxt       = IDLE;
                end else if (out_rdy && !q_empty[grant]) begin
                    q_rd_en[grant] = 1'b1;
                    out_wr_nxt     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= PTR_W'(NUM_QUEUES - 1);
            ctrl_prev <= CTRL_WIDTH'(1);
            out_wr    <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            ctrl_prev <= ctrl_prev_nxt;
            out_wr    <= out_wr_nxt;
        end
    end

endmodule

// File: tb/tb_oq_pkt_scheduler.sv
// Directed bench for oq_pkt_scheduler with behavioural FIFOs (1-cycle read
// latency, flushed by reset). Build with +define+OQ_SCHED_HIPRI_EN to also
// exercise the priority mask.
module tb_oq_pkt_scheduler;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 8;
    localparam int WW = DW + CW;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NQ-1:0]      q_empty;
    logic [NQ-1:0]      q_rd_en;
    logic [NQ*WW-1:0]   q_dout;
    logic [NQ-1:0]      disable_q = '0;
    logic [DW-1:0]      out_data;
    logic [CW-1:0]      out_ctrl;
    logic               out_wr;
    logic               out_rdy = 1'b1;
    logic [NQ-1:0]      pkt_sent;
    logic               busy;
`ifdef OQ_SCHED_HIPRI_EN
    logic [NQ-1:0]      hipri_mask = '0;
`endif

    oq_pkt_scheduler #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .q_empty   (q_empty),
        .q_rd_en   (q_rd_en),
        .q_dout    (q_dout),
        .disable_q (disable_q),
`ifdef OQ_SCHED_HIPRI_EN
        .hipri_mask(hipri_mask),
`endif
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .pkt_sent  (pkt_sent),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FIFOs ----------------
    logic [WW-1:0] mem  [NQ][64];
    logic [WW-1:0] dout [NQ];
    int            head [NQ];
    int            tail [NQ];
    int            cyc = 0;

    initial begin
        for (int i = 0; i < NQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
            dout[i] = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NQ; i++) q_empty[i] = (head[i] == tail[i]);
    end

    for (genvar g = 0; g < NQ; g++) begin : g_dout
        assign q_dout[g*WW +: WW] = dout[g];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NQ; i++) begin
            if (reset) begin
                head[i] <= tail[i];
            end else if (q_rd_en[i] && head[i] != tail[i]) begin
                dout[i] <= mem[i][head[i] % 64];
                head[i] <= head[i] + 1;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [31:0]   log_w   [256];
    int            log_cyc [256];
    int            n_words = 0;
    int            n_pkts  = 0;
    logic [NQ-1:0] last_pkt = '0;
    int            rd_viol = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_wr && n_words < 256) begin
                log_w[n_words]   = {out_ctrl, out_data[23:0]};
                log_cyc[n_words] = cyc;
                n_words++;
            end
            if (pkt_sent != '0) begin
                last_pkt = pkt_sent;
                n_pkts++;
            end
            if (q_rd_en != '0 && !out_rdy)    rd_viol++;
            if (!$onehot0(q_rd_en))           rd_viol++;
            if ((q_rd_en & q_empty) != '0)    rd_viol++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ctrl_of(input int w, input int len);
        if (w == 0)       return 8'hFF;
        if (w == len - 1) return 8'h04;
        return 8'h00;
    endfunction

    function automatic logic [31:0] exp_word(input int q, input int p, input int w, input int len);
        return {ctrl_of(w, len), 8'(q), 8'(p), 8'(w)};
    endfunction

    task automatic push_word(input int q, input int p, input int w, input int len);
        mem[q][tail[q] % 64] = {ctrl_of(w, len), 40'h0, 8'(q), 8'(p), 8'(w)};
        tail[q]++;
    endtask

    task automatic push_pkt(input int q, input int p, input int len);
        for (int w = 0; w < len; w++) push_word(q, p, w, len);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input string tag, input int target, input int budget);
        for (int c = 0; c < budget && n_words < target; c++) @(posedge clk);
        #1;
        check(tag, 64'(n_words >= target), 64'd1);
    endtask

    task automatic do_reset();
        tick(1);
        reset     = 1'b1;
        out_rdy   = 1'b1;
        disable_q = '0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int viol0;

        // ---- reset state ----
        tick(2);
        @(negedge clk);
        check("rst_out_wr",   64'(out_wr),   64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_rd_en",    64'(q_rd_en),  64'd0);
        check("rst_pkt_sent", 64'(pkt_sent), 64'd0);
        tick(1);
        reset = 1'b0;

        // ---- 1: single 4-word packet on Q2 ----
        base = n_words;
        push_pkt(2, 0, 4);
        for (int c = 0; c < 40 && pkt_sent == '0; c++) @(negedge clk);
        check("t1_pkt_sent", 64'(pkt_sent), 64'h04);
        check("t1_eop_ctrl", 64'(out_ctrl), 64'h04);
        check("t1_busy_eop", 64'(busy),     64'd1);
        @(negedge clk);
        check("t1_busy_after", 64'(busy),   64'd0);
        check("t1_wr_after",   64'(out_wr), 64'd0);
        wait_words("t1_count", base + 4, 10);
        for (int w = 0; w < 4; w++) check("t1_word", 64'(log_w[base + w]), 64'(exp_word(2, 0, w, 4)));

        // ---- 2: Q0, Q3, Q7 with two packets each, round-robin order ----
        do_reset();
        base = n_words;
        for (int p = 0; p < 2; p++) begin
            push_pkt(0, p, 3);
            push_pkt(3, p, 3);
            push_pkt(7, p, 3);
        end
        wait_words("t2_count", base + 18, 200);
        begin
            int exp_q[6] = '{0, 3, 7, 0, 3, 7};
            for (int k = 0; k < 6; k++) begin
                for (int w = 0; w < 3; w++)
                    check("t2_word", 64'(log_w[base + 3*k + w]), 64'(exp_word(exp_q[k], k / 3, w, 3)));
                if (k < 5)
                    check("t2_gap", 64'(log_cyc[base + 3*k + 3] - log_cyc[base + 3*k + 2]), 64'd3);
            end
        end

        // ---- 3: Q1 runs dry after word 2 of 5, refilled 10 cycles later ----
        do_reset();
        base = n_words;
        push_word(1, 0, 0, 5);
        push_word(1, 0, 1, 5);
        wait_words("t3_first2", base + 2, 40);
        begin
            int stall_wr = 0;
            int stall_idle = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (out_wr) stall_wr++;
                if (!busy)  stall_idle++;
            end
            check("t3_stall_wr",   64'(stall_wr),   64'd0);
            check("t3_stall_busy", 64'(stall_idle), 64'd0);
        end
        tick(1);
        for (int w = 2; w < 5; w++) push_word(1, 0, w, 5);
        wait_words("t3_count", base + 5, 40);
        for (int w = 0; w < 5; w++) check("t3_word", 64'(log_w[base + w]), 64'(exp_word(1, 0, w, 5)));
        tick(2);
        check("t3_pkt_sent", 64'(last_pkt), 64'h02);

        // ---- 4: out_rdy toggling during a packet ----
        do_reset();
        base  = n_words;
        viol0 = rd_viol;
        push_pkt(5, 0, 6);
        for (int c = 0; c < 30; c++) begin
            tick(1);
            out_rdy = ~out_rdy;
        end
        out_rdy = 1'b1;
        tick(10);
        check("t4_count", 64'(n_words - base), 64'd6);
        for (int w = 0; w < 6; w++) check("t4_word", 64'(log_w[base + w]), 64'(exp_word(5, 0, w, 6)));
        check("t4_rd_viol", 64'(rd_viol - viol0), 64'd0);

        // ---- 5: disabled queue skipped; disable mid-packet ----
        do_reset();
        disable_q = 8'h02;
        base = n_words;
        push_pkt(1, 0, 3);
        push_pkt(4, 0, 3);
        tick(30);
        check("t5_count",    64'(n_words - base), 64'd3);
        check("t5_src",      64'(log_w[base]),    64'(exp_word(4, 0, 0, 3)));
        check("t5_pkt_sent", 64'(last_pkt),       64'h10);
        base = n_words;
        push_pkt(4, 1, 4);
        push_pkt(4, 2, 3);
        wait_words("t5_start", base + 1, 40);
        disable_q = 8'h12;
        tick(30);
        check("t5_finish", 64'(n_words - base), 64'd4);
        check("t5_last",   64'(log_w[base + 3]), 64'(exp_word(4, 1, 3, 4)));
        check("t5_idle",   64'(busy),            64'd0);

        // ---- 6: reset mid-packet, then Q0 first ----
        do_reset();
        base = n_words;
        push_pkt(6, 0, 6);
        wait_words("t6_start", base + 2, 40);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_out_wr", 64'(out_wr),  64'd0);
        check("t6_rst_busy",   64'(busy),    64'd0);
        check("t6_rst_rd_en",  64'(q_rd_en), 64'd0);
        tick(2);
        reset = 1'b0;
        base = n_words;
        push_pkt(6, 1, 3);
        push_pkt(0, 1, 3);
        wait_words("t6_count", base + 6, 60);
        check("t6_first",  64'(log_w[base]),     64'(exp_word(0, 1, 0, 3)));
        check("t6_second", 64'(log_w[base + 3]), 64'(exp_word(6, 1, 0, 3)));

`ifdef OQ_SCHED_HIPRI_EN
        // ---- high-priority mask: Q5 first, rr_ptr left at 7 ----
        do_reset();
        hipri_mask = 8'h20;
        base = n_words;
        push_pkt(0, 2, 3);
        push_pkt(5, 2, 3);
        push_pkt(7, 2, 3);
        wait_words("hp_count", base + 9, 100);
        check("hp_first",  64'(log_w[base]),     64'(exp_word(5, 2, 0, 3)));
        check("hp_second", 64'(log_w[base + 3]), 64'(exp_word(0, 2, 0, 3)));
        check("hp_third",  64'(log_w[base + 6]), 64'(exp_word(7, 2, 0, 3)));
        hipri_mask = '0;
`endif

        check("rd_protocol", 64'(rd_viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
